// File: rtl/card_pkg.sv
// Shared types and constants for the card deal stage.
package card_pkg;

    typedef logic [3:0] card_t;

    localparam card_t       CARD_EMPTY = 4'd0;
    localparam int unsigned NUM_SLOTS  = 6;

    // Slot deal order; SLOT_DONE marks a fully consumed round.
    typedef enum logic [2:0] {
        SLOT_P1   = 3'd0,
        SLOT_D1   = 3'd1,
        SLOT_P2   = 3'd2,
        SLOT_D2   = 3'd3,
        SLOT_P3   = 3'd4,
        SLOT_D3   = 3'd5,
        SLOT_DONE = 3'd6
    } slot_e;

    typedef enum logic [0:0] {
        ST_IDLE_DEAL = 1'b0,
        ST_DONE      = 1'b1
    } state_e;

endpackage

// File: rtl/card_counter.sv
// Free-running card value counter, 1..CARD_MAX, wrapping back to 1.
// Ports: clk, resetb (sync, active-low), count (current card value).
module card_counter
    import card_pkg::*;
#(
    parameter int unsigned CARD_MAX   = 13,
    parameter int unsigned CARD_START = 1
) (
    input  logic  clk,
    input  logic  resetb,
    output card_t count
);

    // Wrap straight to 1 so the counter never shows the empty value.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            count <= 4'(CARD_START);
        end else if (count == 4'(CARD_MAX)) begin
            count <= 4'(1);
        end else begin
            count <= count + 4'(1);
        end
    end

endmodule

// File: rtl/card_dealer.sv
// Deal stage: samples the running card counter into six slots in the
// order P1, D1, P2, D2, P3, D3.
// Ports: clk, resetb (sync, active-low); new_round, deal, skip requests;
// deal_ready, done (decoded from state); dealt (registered load pulse);
// pcard1..3 / dcard1..3 card slots (0 = empty); slot_idx next slot (6 = done).
module card_dealer
    import card_pkg::*;
#(
    parameter int unsigned CARD_MAX   = 13,
    parameter int unsigned CARD_START = 1
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       new_round,
    input  logic       deal,
    input  logic       skip,
    output logic       deal_ready,
    output logic       dealt,
    output logic       done,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [2:0] slot_idx
);

    card_t  count;
    state_e state_q, state_d;
    slot_e  slot_q, slot_d;
    logic   load_c;
    logic   clear_c;
    card_t  slots_q [NUM_SLOTS];
    logic   dealt_q;

    card_counter #(
        .CARD_MAX   (CARD_MAX),
        .CARD_START (CARD_START)
    ) u_counter (
        .clk    (clk),
        .resetb (resetb),
        .count  (count)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q <= ST_IDLE_DEAL;
            slot_q  <= SLOT_P1;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    // Next state: new_round wins, then deal, then skip; DONE ignores both.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        load_c  = 1'b0;
        clear_c = 1'b0;
        if (new_round) begin
            clear_c = 1'b1;
            state_d = ST_IDLE_DEAL;
            slot_d  = SLOT_P1;
        end else if (state_q == ST_IDLE_DEAL && (deal || skip)) begin
            load_c = deal;
            if (slot_q == SLOT_D3) begin
                slot_d  = SLOT_DONE;
                state_d = ST_DONE;
            end else begin
                slot_d = slot_e'(slot_q + 3'd1);
            end
        end
    end

    // Slot registers and dealt pulse; a load captures the pre-edge count.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            dealt_q <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_q[i] <= CARD_EMPTY;
            end
        end else begin
            dealt_q <= load_c;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (clear_c) begin
                    slots_q[i] <= CARD_EMPTY;
                end else if (load_c && slot_q == slot_e'(3'(i))) begin
                    slots_q[i] <= count;
                end
            end
        end
    end

    assign deal_ready = (state_q == ST_IDLE_DEAL);
    assign done       = (state_q == ST_DONE);
    assign dealt      = dealt_q;
    assign slot_idx   = slot_q;
    assign pcard1     = slots_q[0];
    assign dcard1     = slots_q[1];
    assign pcard2     = slots_q[2];
    assign dcard2     = slots_q[3];
    assign pcard3     = slots_q[4];
    assign dcard3     = slots_q[5];

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: directed vector table plus randomized run
// against a simple array-based model.
module tb_card_dealer;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       new_round = 1'b0;
    logic       deal = 1'b0;
    logic       skip = 1'b0;
    logic       deal_ready, dealt, done;
    logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
    logic [2:0] slot_idx;

    int vectors = 0;
    int miscompares = 0;

    card_dealer #(.CARD_MAX(13), .CARD_START(1)) dut (
        .clk        (clk),
        .resetb     (resetb),
        .new_round  (new_round),
        .deal       (deal),
        .skip       (skip),
        .deal_ready (deal_ready),
        .dealt      (dealt),
        .done       (done),
        .pcard1     (pcard1),
        .pcard2     (pcard2),
        .pcard3     (pcard3),
        .dcard1     (dcard1),
        .dcard2     (dcard2),
        .dcard3     (dcard3),
        .slot_idx   (slot_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        bit              rb, nr, dl, sk;
        logic [5:0][3:0] cards;   // [0]=P1 .. [5]=D3
        logic [2:0]      idx;
        bit              dealt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string n, input bit rb, input bit nr, input bit dl, input bit sk,
                       input int p1, input int d1, input int p2, input int d2,
                       input int p3, input int d3, input int idx, input bit dt);
        vec_t v;
        v.name = n; v.rb = rb; v.nr = nr; v.dl = dl; v.sk = sk;
        v.cards[0] = 4'(p1); v.cards[1] = 4'(d1); v.cards[2] = 4'(p2);
        v.cards[3] = 4'(d2); v.cards[4] = 4'(p3); v.cards[5] = 4'(d3);
        v.idx = 3'(idx); v.dealt = dt;
        vq.push_back(v);
    endtask

    // Apply inputs at one rising edge, then compare every output after it.
    task automatic step_check(input string n, input bit rb, input bit nr, input bit dl,
                              input bit sk, input logic [5:0][3:0] ec,
                              input logic [2:0] eidx, input bit edt);
        logic [5:0][3:0] got;
        bit              edone;
        resetb = rb; new_round = nr; deal = dl; skip = sk;
        @(posedge clk);
        #1;
        got   = {dcard3, pcard3, dcard2, pcard2, dcard1, pcard1};
        edone = (eidx == 3'd6);
        vectors++;
        if (got !== ec || slot_idx !== eidx || dealt !== edt ||
            done !== edone || deal_ready !== !edone) begin
            miscompares++;
            $display("FAIL %s: got cards=%h idx=%0d dealt=%b done=%b rdy=%b, want cards=%h idx=%0d dealt=%b done=%b rdy=%b",
                     n, got, slot_idx, dealt, done, deal_ready, ec, eidx, edt, edone, !edone);
        end
    endtask

    // Reference model state.
    int m_cards [6];
    int m_idx;
    int m_cnt;
    bit m_dealt;

    task automatic model_edge(input bit rb, input bit nr, input bit dl, input bit sk);
        if (!rb) begin
            foreach (m_cards[i]) m_cards[i] = 0;
            m_idx = 0; m_dealt = 0; m_cnt = 1;
        end else begin
            m_dealt = 0;
            if (nr) begin
                foreach (m_cards[i]) m_cards[i] = 0;
                m_idx = 0;
            end else if (m_idx < 6 && (dl || sk)) begin
                if (dl) begin
                    m_cards[m_idx] = m_cnt;
                    m_dealt = 1;
                end
                m_idx++;
            end
            m_cnt = (m_cnt % 13) + 1;
        end
    endtask

    initial begin
        // Counter after reset edge = 1; each row notes the value sampled.
        add("reset", 0,0,0,0, 0,0,0,0,0,0, 0,0);
        for (int i = 0; i < 4; i++) add("idle4", 1,0,0,0, 0,0,0,0,0,0, 0,0); // 1..4
        add("deal5",   1,0,1,0, 5,0,0,0,0,0, 1,1);
        add("hold5",   1,0,0,0, 5,0,0,0,0,0, 1,0);   // 6
        add("nr7",     1,1,0,0, 0,0,0,0,0,0, 0,0);
        for (int i = 0; i < 5; i++) add("idle5", 1,0,0,0, 0,0,0,0,0,0, 0,0); // 8..12
        add("wrap13",  1,0,1,0, 13,0,0,0,0,0, 1,1);
        add("wrap1",   1,0,1,0, 13,1,0,0,0,0, 2,1);
        add("nr2",     1,1,0,0, 0,0,0,0,0,0, 0,0);
        add("full3",   1,0,1,0, 3,0,0,0,0,0, 1,1);
        add("full4",   1,0,1,0, 3,4,0,0,0,0, 2,1);
        add("full5",   1,0,1,0, 3,4,5,0,0,0, 3,1);
        add("full6",   1,0,1,0, 3,4,5,6,0,0, 4,1);
        add("full7",   1,0,1,0, 3,4,5,6,7,0, 5,1);
        add("full8",   1,0,1,0, 3,4,5,6,7,8, 6,1);
        add("done_dl", 1,0,1,0, 3,4,5,6,7,8, 6,0);   // 9 ignored
        add("done_sk", 1,0,0,1, 3,4,5,6,7,8, 6,0);   // 10 ignored
        add("nr_done", 1,1,1,0, 0,0,0,0,0,0, 0,0);   // 11
        add("sp12",    1,0,1,0, 12,0,0,0,0,0, 1,1);
        add("sp13",    1,0,1,0, 12,13,0,0,0,0, 2,1);
        add("sp1",     1,0,1,0, 12,13,1,0,0,0, 3,1);
        add("sp2",     1,0,1,0, 12,13,1,2,0,0, 4,1);
        add("skip3",   1,0,0,1, 12,13,1,2,0,0, 5,0);
        add("sp4",     1,0,1,0, 12,13,1,2,0,4, 6,1);
        add("nr5",     1,1,0,0, 0,0,0,0,0,0, 0,0);
        add("ds6",     1,0,1,0, 6,0,0,0,0,0, 1,1);
        add("ds7",     1,0,1,0, 6,7,0,0,0,0, 2,1);
        add("ds8",     1,0,1,0, 6,7,8,0,0,0, 3,1);
        add("ds9",     1,0,1,0, 6,7,8,9,0,0, 4,1);
        add("dlsk10",  1,0,1,1, 6,7,8,9,10,0, 5,1);
        add("nr11",    1,1,0,0, 0,0,0,0,0,0, 0,0);
        add("m12",     1,0,1,0, 12,0,0,0,0,0, 1,1);
        add("m13",     1,0,1,0, 12,13,0,0,0,0, 2,1);
        add("m1",      1,0,1,0, 12,13,1,0,0,0, 3,1);
        add("nr_dl2",  1,1,1,0, 0,0,0,0,0,0, 0,0);
        add("cont3",   1,0,1,0, 3,0,0,0,0,0, 1,1);
        add("r4",      1,0,1,0, 3,4,0,0,0,0, 2,1);
        add("r5",      1,0,1,0, 3,4,5,0,0,0, 3,1);
        add("r6",      1,0,1,0, 3,4,5,6,0,0, 4,1);
        add("rst_mid", 0,0,1,0, 0,0,0,0,0,0, 0,0);
        add("start1",  1,0,1,0, 1,0,0,0,0,0, 1,1);

        foreach (vq[i]) begin
            step_check(vq[i].name, vq[i].rb, vq[i].nr, vq[i].dl, vq[i].sk,
                       vq[i].cards, vq[i].idx, vq[i].dealt);
        end

        // Randomized run; first edge is a forced reset to sync the model.
        for (int n = 0; n < 3000; n++) begin
            bit              rb, nr, dl, sk;
            logic [5:0][3:0] ec;
            rb = (n == 0) ? 1'b0 : ($urandom_range(63) != 0);
            nr = ($urandom_range(15) == 0);
            dl = ($urandom_range(1) == 1);
            sk = ($urandom_range(3) == 0);
            model_edge(rb, nr, dl, sk);
            for (int s = 0; s < 6; s++) ec[s] = 4'(m_cards[s]);
            step_check("random", rb, nr, dl, sk, ec, 3'(m_idx), m_dealt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
